// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the control pipeline:
// control bundle, write-back bundle, ALUOp and forward encodings.
package ctrl_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  alusrc;
    logic [1:0]            aluop;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] wa;
  } ctrl_t;

  typedef struct packed {
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] wa;
  } wr_t;

  localparam ctrl_t CTRL_BUBBLE = '0;
  localparam wr_t   WR_BUBBLE   = '0;

  function automatic logic [1:0] fwd_sel(
    input logic mem_hit,
    input logic wb_hit
  );
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decoder-to-pipeline control interface plus the
// per-stage control returned to the datapath.
interface ctrl_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);

  logic              valid_i;
  logic              stall_i;
  logic              flush_i;
  logic              RegDst_i;
  logic              ALUSrc_i;
  logic              RegWrite_i;
  logic [1:0]        ALUOp_i;
  logic [ADDR_W-1:0] rs_i;
  logic [ADDR_W-1:0] rt_i;
  logic [ADDR_W-1:0] rd_i;

  logic              ex_valid_o;
  logic              ex_ALUSrc_o;
  logic [1:0]        ex_ALUOp_o;
  logic [ADDR_W-1:0] ex_rs_o;
  logic [ADDR_W-1:0] ex_rt_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              mem_RegWrite_o;
  logic [ADDR_W-1:0] mem_wa_o;
  logic              wb_RegWrite_o;
  logic [ADDR_W-1:0] wb_wa_o;
  logic [CNT_W-1:0]  retired_o;

  modport master (
    output valid_i, stall_i, flush_i,
    output RegDst_i, ALUSrc_i, RegWrite_i, ALUOp_i,
    output rs_i, rt_i, rd_i,
    input  ex_valid_o, ex_ALUSrc_o, ex_ALUOp_o,
    input  ex_rs_o, ex_rt_o, fwd_a_o, fwd_b_o,
    input  mem_RegWrite_o, mem_wa_o,
    input  wb_RegWrite_o, wb_wa_o, retired_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i,
    input  RegDst_i, ALUSrc_i, RegWrite_i, ALUOp_i,
    input  rs_i, rt_i, rd_i,
    output ex_valid_o, ex_ALUSrc_o, ex_ALUOp_o,
    output ex_rs_o, ex_rt_o, fwd_a_o, fwd_b_o,
    output mem_RegWrite_o, mem_wa_o,
    output wb_RegWrite_o, wb_wa_o, retired_o
  );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage forwarding select generation, MEM over WB.
// Purely combinational; r0 is excluded upstream via RegWrite.
module fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_wa_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_wa_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [ADDR_W-1:0] rt_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  logic mem_hit_a;
  logic mem_hit_b;
  logic wb_hit_a;
  logic wb_hit_b;

  always_comb begin
    mem_hit_a = mem_we_i && (mem_wa_i == rs_i);
    mem_hit_b = mem_we_i && (mem_wa_i == rt_i);
    wb_hit_a  = wb_we_i  && (wb_wa_i  == rs_i);
    wb_hit_b  = wb_we_i  && (wb_wa_i  == rt_i);
    fwd_a_o   = fwd_sel(mem_hit_a, wb_hit_a);
    fwd_b_o   = fwd_sel(mem_hit_b, wb_hit_b);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers with write-address
// resolution, stall/flush handling and a retired counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  ctrl_pipe_if.slave bus
);

  logic [ADDR_W-1:0] id_wa;
  ctrl_t             id_bundle;

  ctrl_t             idex_d;
  ctrl_t             idex_q;
  logic              exmem_valid_d;
  logic              exmem_valid_q;
  wr_t               exmem_d;
  wr_t               exmem_q;
  wr_t               memwb_d;
  wr_t               memwb_q;
  logic [CNT_W-1:0]  retired_d;
  logic [CNT_W-1:0]  retired_q;

  // Invalid ID slots become bubbles so stale fields never leak.
  always_comb begin
    id_wa     = bus.RegDst_i ? bus.rd_i : bus.rt_i;
    id_bundle = CTRL_BUBBLE;
    if (bus.valid_i) begin
      id_bundle.valid    = 1'b1;
      id_bundle.regwrite = bus.RegWrite_i && (id_wa != '0);
      id_bundle.alusrc   = bus.ALUSrc_i;
      id_bundle.aluop    = bus.ALUOp_i;
      id_bundle.rs       = bus.rs_i;
      id_bundle.rt       = bus.rt_i;
      id_bundle.wa       = id_wa;
    end
  end

  always_comb begin
    idex_d = id_bundle;
    if (bus.flush_i) begin
      idex_d = CTRL_BUBBLE;
    end else if (bus.stall_i) begin
      idex_d = idex_q;
    end
  end

  // A held ID/EX entry must not also advance into MEM.
  always_comb begin
    exmem_valid_d    = idex_q.valid;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.wa       = idex_q.wa;
    if (bus.stall_i && !bus.flush_i) begin
      exmem_valid_d = 1'b0;
      exmem_d       = WR_BUBBLE;
    end
  end

  always_comb begin
    memwb_d   = exmem_q;
    retired_d = retired_q + CNT_W'(exmem_valid_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q        <= CTRL_BUBBLE;
      exmem_valid_q <= 1'b0;
      exmem_q       <= WR_BUBBLE;
      memwb_q       <= WR_BUBBLE;
      retired_q     <= '0;
    end else begin
      idex_q        <= idex_d;
      exmem_valid_q <= exmem_valid_d;
      exmem_q       <= exmem_d;
      memwb_q       <= memwb_d;
      retired_q     <= retired_d;
    end
  end

  assign bus.ex_valid_o     = idex_q.valid;
  assign bus.ex_ALUSrc_o    = idex_q.alusrc;
  assign bus.ex_ALUOp_o     = idex_q.aluop;
  assign bus.ex_rs_o        = idex_q.rs;
  assign bus.ex_rt_o        = idex_q.rt;
  assign bus.mem_RegWrite_o = exmem_q.regwrite;
  assign bus.mem_wa_o       = exmem_q.wa;
  assign bus.wb_RegWrite_o  = memwb_q.regwrite;
  assign bus.wb_wa_o        = memwb_q.wa;
  assign bus.retired_o      = retired_q;

  fwd_unit #(
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .mem_we_i (exmem_q.regwrite),
    .mem_wa_i (exmem_q.wa),
    .wb_we_i  (memwb_q.regwrite),
    .wb_wa_i  (memwb_q.wa),
    .rs_i     (idex_q.rs),
    .rt_i     (idex_q.rt),
    .fwd_a_o  (bus.fwd_a_o),
    .fwd_b_o  (bus.fwd_b_o)
  );

endmodule
